// File: rtl/irq_pending_encoder_8x3.sv
// Sticky request latch with masked highest-index-first selection.
// Each selected index is presented exactly once on a valid/ready port.
module irq_pending_encoder_8x3 #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         overflow
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] idx_q, idx_d;
    logic         ovf_q, ovf_d;

    logic [N-1:0] elig;
    logic [W-1:0] sel;
    logic         any_elig;
    logic         load;
    logic [N-1:0] take;

    // Ascending scan: the last hit is the highest eligible index.
    always_comb begin
        elig     = pend_q & mask;
        any_elig = |elig;
        sel      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (elig[i]) begin
                sel = W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    load    = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (out_ready) begin
                    if (any_elig) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            idx_d = sel;
        end
    end

    // A request on a bit being taken this edge is a fresh event, not a loss.
    always_comb begin
        take = '0;
        if (load) begin
            take[sel] = 1'b1;
        end
        pend_d = (pend_q & ~take) | req;
        ovf_d  = ovf_q | (|(req & pend_q & ~take));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == SHOW);
    assign out_idx   = idx_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_irq_pending_encoder_8x3.sv
// Directed bench for irq_pending_encoder_8x3: expected indices and handshake
// cycles are queued by the stimulus and checked by an independent monitor.
module tb_irq_pending_encoder_8x3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic       overflow;

    irq_pending_encoder_8x3 #(.N(8), .W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  idx;
        int unsigned cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic expect_idx(input logic [2:0] idx, input int unsigned at);
        exp_t e;
        e.idx = idx;
        e.cyc = at;
        q.push_back(e);
    endtask

    // Monitor: every accepted handshake must match the next queued index and cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got idx %0d with no expected entry (cycle %0d)", out_idx, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_idx", 32'(out_idx), 32'(e.idx));
                chk("sb_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int unsigned c0;

    initial begin
        // 1: reset with all requests asserted
        rst = 1'b1; req = 8'hFF; mask = 8'hFF; out_ready = 1'b1;
        tick(2);
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_idx", 32'(out_idx), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        rst = 1'b0; req = 8'h00;
        tick(2);
        chk("post_rst_pending", 32'(pending), 32'h00);
        chk("post_rst_valid", 32'(out_valid), 32'h0);

        // 2: single request, two-cycle latency
        req = 8'h04; c0 = cyc;
        expect_idx(3'd2, c0 + 2);
        tick(1); req = 8'h00;
        chk("single_c1_pending", 32'(pending), 32'h04);
        chk("single_c1_valid", 32'(out_valid), 32'h0);
        tick(1);
        chk("single_c2_valid", 32'(out_valid), 32'h1);
        chk("single_c2_pending", 32'(pending), 32'h00);
        tick(1);
        chk("single_c3_valid", 32'(out_valid), 32'h0);
        tick(1);

        // 3: priority burst, back-to-back
        req = 8'hB0; c0 = cyc;
        expect_idx(3'd7, c0 + 2);
        expect_idx(3'd5, c0 + 3);
        expect_idx(3'd4, c0 + 4);
        tick(1); req = 8'h00;
        tick(1);
        chk("burst_c2_pending", 32'(pending), 32'h30);
        tick(3);
        chk("burst_c5_valid", 32'(out_valid), 32'h0);
        chk("burst_c5_pending", 32'(pending), 32'h00);
        tick(1);

        // 4: backpressure holds the presented index
        out_ready = 1'b0; req = 8'h01; c0 = cyc;
        tick(1); req = 8'h00;
        tick(2);
        chk("bp_c3_valid", 32'(out_valid), 32'h1);
        chk("bp_c3_idx", 32'(out_idx), 32'h0);
        req = 8'h80;
        tick(1); req = 8'h00;
        chk("bp_c4_pending", 32'(pending), 32'h80);
        chk("bp_c4_idx", 32'(out_idx), 32'h0);
        tick(2);
        chk("bp_c6_idx", 32'(out_idx), 32'h0);
        chk("bp_c6_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        expect_idx(3'd0, c0 + 6);
        expect_idx(3'd7, c0 + 7);
        tick(1);
        chk("bp_c7_idx", 32'(out_idx), 32'h7);
        tick(1);
        chk("bp_c8_valid", 32'(out_valid), 32'h0);
        tick(1);

        // 5: masked bits retained, then released in priority order
        mask = 8'h0F; req = 8'hF0; c0 = cyc;
        tick(1); req = 8'h00;
        tick(3);
        chk("mask_c4_valid", 32'(out_valid), 32'h0);
        chk("mask_c4_pending", 32'(pending), 32'hF0);
        mask = 8'hFF;
        expect_idx(3'd7, c0 + 5);
        expect_idx(3'd6, c0 + 6);
        expect_idx(3'd5, c0 + 7);
        expect_idx(3'd4, c0 + 8);
        tick(5);
        chk("mask_c9_valid", 32'(out_valid), 32'h0);
        chk("mask_c9_pending", 32'(pending), 32'h00);
        tick(1);

        // 6: overflow from a held request, cleared by reset mid-presentation
        out_ready = 1'b0; req = 8'h02;
        tick(2);
        chk("ovf_c2_valid", 32'(out_valid), 32'h1);
        chk("ovf_c2_idx", 32'(out_idx), 32'h1);
        chk("ovf_c2_overflow", 32'(overflow), 32'h0);
        tick(1); req = 8'h00;
        chk("ovf_c3_overflow", 32'(overflow), 32'h1);
        chk("ovf_c3_pending", 32'(pending), 32'h02);
        rst = 1'b1;
        tick(1); rst = 1'b0;
        chk("ovf_rst_valid", 32'(out_valid), 32'h0);
        chk("ovf_rst_pending", 32'(pending), 32'h00);
        chk("ovf_rst_overflow", 32'(overflow), 32'h0);
        chk("ovf_rst_idx", 32'(out_idx), 32'h0);
        out_ready = 1'b1;
        tick(3);
        chk("final_valid", 32'(out_valid), 32'h0);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
